// File: rtl/f_div_pkg.sv
// f_div_pkg: shared definitions for the programmable clock-divider controller.
//   state_t      : controller state encoding (OFF, RUN, PEND, STOP)
//   DIV_MIN      : smallest ratio the divider can produce
//   is_legal_div : ratio legality check used by the request handshake
package f_div_pkg;

  typedef enum logic [1:0] {
    OFF  = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2,
    STOP = 2'd3
  } state_t;

  localparam int unsigned DIV_MIN = 2;

  // A ratio below 2 cannot produce a clock with both a high and a low phase.
  function automatic logic is_legal_div(input logic [31:0] v);
    return (v >= DIV_MIN);
  endfunction

endpackage

// File: rtl/f_div_core.sv
// f_div_core: period counter plus registered clk_out / tick generation.
// Ports:
//   clk_in   in   fast clock
//   rst      in   asynchronous active-low reset
//   run      in   divider is counting in the next cycle (low clears everything)
//   restart  in   start a fresh period (cnt=0) instead of continuing
//   n        in   ratio in effect for the current cycle (drives wrap detection)
//   n_nxt    in   ratio in effect for the next cycle (drives clk_out/tick)
//   boundary out  current cycle is the last of the period (cnt == n-1)
//   clk_out  out  registered divided clock, high while cnt < n/2
//   tick     out  registered, high while cnt == n-1
module f_div_core
  import f_div_pkg::*;
#(
  parameter int DIV_W = 4
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             run,
  input  logic             restart,
  input  logic [DIV_W-1:0] n,
  input  logic [DIV_W-1:0] n_nxt,
  output logic             boundary,
  output logic             clk_out,
  output logic             tick
);

  localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] cnt_nxt;

  assign boundary = (cnt == (n - ONE));

  always_comb begin
    cnt_nxt = cnt + ONE;
    if (restart || boundary) begin
      cnt_nxt = '0;
    end
  end

  // clk_out and tick are computed from the next count and the next ratio so
  // that, once registered, they line up with cnt in the same cycle. A ratio
  // switch at a boundary therefore shapes the very first cycle correctly.
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      cnt     <= '0;
      clk_out <= 1'b0;
      tick    <= 1'b0;
    end else if (!run) begin
      cnt     <= '0;
      clk_out <= 1'b0;
      tick    <= 1'b0;
    end else begin
      cnt     <= cnt_nxt;
      clk_out <= (cnt_nxt < (n_nxt >> 1));
      tick    <= (cnt_nxt == (n_nxt - ONE));
    end
  end

endmodule

// File: rtl/f_div_ctrl.sv
// f_div_ctrl: glitch-free programmable divider controller. Owns the run/stop
// FSM and the ratio-change handshake; the counter lives in f_div_core.
// Ports:
//   clk_in   in   fast clock, all state changes on its rising edge
//   rst      in   asynchronous active-low reset
//   en       in   run enable (level)
//   div_req  in   ratio change request, held until div_ack
//   div_val  in   requested ratio, stable while div_req is high
//   div_ack  out  one-cycle acknowledge
//   div_err  out  one-cycle reject flag, coincident with div_ack
//   busy     out  a ratio change is queued, waiting for a period boundary
//   cur_div  out  ratio currently in effect
//   clk_out  out  registered divided clock
//   tick     out  one-cycle pulse in the last cycle of each period
module f_div_ctrl
  import f_div_pkg::*;
#(
  parameter int DIV_W       = 4,
  parameter int DEFAULT_DIV = 2
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             en,
  input  logic             div_req,
  input  logic [DIV_W-1:0] div_val,
  output logic             div_ack,
  output logic             div_err,
  output logic             busy,
  output logic [DIV_W-1:0] cur_div,
  output logic             clk_out,
  output logic             tick
);

  state_t           state, state_n;
  logic [DIV_W-1:0] cur_div_n;
  logic [DIV_W-1:0] pend_div, pend_div_n;
  logic             busy_n, ack_n, err_n;
  logic             take, legal, core_bnd, bnd;
  logic             run, restart;

  // A request is only looked at when no acknowledge is in flight and nothing
  // is already queued, so a held div_req is never double-counted.
  assign take  = div_req && !div_ack && !busy;
  assign legal = is_legal_div(32'(div_val));
  assign bnd   = core_bnd && (state != OFF);

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      state    <= OFF;
      cur_div  <= DIV_W'(DEFAULT_DIV);
      pend_div <= '0;
      busy     <= 1'b0;
      div_ack  <= 1'b0;
      div_err  <= 1'b0;
    end else begin
      state    <= state_n;
      cur_div  <= cur_div_n;
      pend_div <= pend_div_n;
      busy     <= busy_n;
      div_ack  <= ack_n;
      div_err  <= err_n;
    end
  end

  always_comb begin
    state_n    = state;
    cur_div_n  = cur_div;
    pend_div_n = pend_div;
    busy_n     = busy;
    ack_n      = 1'b0;
    err_n      = 1'b0;

    if (take && !legal) begin
      ack_n = 1'b1;
      err_n = 1'b1;
    end

    case (state)
      OFF: begin
        // Nothing is running, so a legal ratio can be applied immediately.
        if (take && legal) begin
          cur_div_n = div_val;
          ack_n     = 1'b1;
        end
        if (en) begin
          state_n = RUN;
        end
      end

      RUN, PEND, STOP: begin
        // take implies busy==0, so queueing and applying never overlap.
        if (take && legal) begin
          if (bnd && !en) begin
            // Divider is about to stop: treat it like a request in OFF.
            cur_div_n = div_val;
            ack_n     = 1'b1;
          end else begin
            pend_div_n = div_val;
            busy_n     = 1'b1;
          end
        end
        if (bnd && busy) begin
          cur_div_n = pend_div;
          busy_n    = 1'b0;
          ack_n     = 1'b1;
        end
        // en only matters at a boundary: a period, once started, always
        // completes, and en returning before the boundary resumes running.
        if (bnd && !en) begin
          state_n = OFF;
        end else if (!en) begin
          state_n = STOP;
        end else if (busy_n) begin
          state_n = PEND;
        end else begin
          state_n = RUN;
        end
      end

      default: begin
        state_n = OFF;
      end
    endcase
  end

  assign run     = (state_n != OFF);
  assign restart = (state == OFF);

  f_div_core #(
    .DIV_W(DIV_W)
  ) u_core (
    .clk_in  (clk_in),
    .rst     (rst),
    .run     (run),
    .restart (restart),
    .n       (cur_div),
    .n_nxt   (cur_div_n),
    .boundary(core_bnd),
    .clk_out (clk_out),
    .tick    (tick)
  );

endmodule

// File: doc/f_div_ctrl.md
Name: f_div_ctrl

Overview:
Programmable, glitch-free divider controller that sequences the frequency-divider datapath from one fast clock. It generates a divided clock (clk_out) and a one-cycle period tick for a runtime-selectable ratio N. Ratio changes come through a req/ack handshake and take effect only on a period boundary, so clk_out never produces a runt pulse. It sits between the configuration logic and the clock-consuming blocks that currently use fixed 2x/3x/4x/5x outputs.

Parameters:
DIV_W, 4, width of the ratio field; legal N is 2..2^DIV_W-1.
DEFAULT_DIV, 2, ratio loaded at reset.

Ports:
clk_in  input  1  single clock; all state updates on the rising edge.
rst  input  1  asynchronous, active-low reset.
en  input  1  run enable, level.
div_req  input  1  ratio change request, held until div_ack.
div_val  input  DIV_W  requested ratio N, stable while div_req=1.
div_ack  output  1  one-cycle acknowledge for the request.
div_err  output  1  one-cycle flag, coincident with div_ack, when the request is rejected.
busy  output  1  high while a change is pending (PEND state).
cur_div  output  DIV_W  ratio currently in effect.
clk_out  output  1  registered divided clock.
tick  output  1  registered, high for one clk_in cycle when cnt==N-1.

Behaviour:
- Reset (rst=0, asynchronous): state=OFF, cnt=0, cur_div=DEFAULT_DIV, pend_div=0, clk_out=0, tick=0, div_ack=0, div_err=0, busy=0.
- Counter cnt (DIV_W bits) counts 0..N-1 in RUN/PEND/STOP and wraps to 0 after N-1. The cycle in which cnt returns to 0 is the "boundary".
- clk_out is a flop output. Its value during a cycle with count k is 1 iff k < floor(N/2). For odd N it is low for the extra cycle (N=3: 1 high, 2 low; N=5: 2 high, 3 low).
- tick is a flop output, equal to 1 during the cycle where cnt==N-1.
- States:
  - OFF: cnt=0, clk_out=0, tick=0.
  - RUN: counting at cur_div.
  - PEND: counting at cur_div with a change queued.
  - STOP: en has fallen; the current period is finishing.
- Transitions:
  - OFF -> RUN when en=1. The first RUN cycle has cnt=0 and clk_out=1.
  - RUN -> PEND on an accepted div_req.
  - PEND -> RUN at the boundary. At that boundary cur_div<=pend_div and cnt restarts at 0 under the new N. div_ack pulses in the first cycle of the new period.
  - RUN/PEND -> STOP when en=0. The queued change stays queued.
  - STOP -> OFF at the next boundary. Any pending change applies there, with its div_ack.
  - STOP -> RUN/PEND if en returns to 1 before the boundary. No truncation occurs.
- Request acceptance:
  - div_req is sampled only when div_ack=0 and busy=0. It is ignored in the cycle ack is high; the requester drops req on seeing ack.
  - Illegal div_val (0 or 1): no state change; div_ack=div_err=1 on the next cycle, in any state.
  - Legal request in OFF: cur_div updates next cycle with div_ack; there is no PEND.
  - Legal request with div_val==cur_div in RUN: still passes through PEND and acks at the boundary. Behaviour is uniform.
  - div_req held high in PEND is not re-sampled until ack.
- Simultaneous events:
  - en falling in the same cycle as a legal req in RUN: both take effect (STOP with pending change).
  - rst asserted mid-period: immediate asynchronous clear. A truncated clk_out pulse is allowed only on reset.
- Arithmetic: all compares are unsigned DIV_W-bit. floor(N/2) is N>>1. No overflow is possible since N <= 2^DIV_W-1.

Decomposition:
- Shared package f_div_pkg: state enum (OFF, RUN, PEND, STOP), DIV_MIN=2 constant, and the is_legal_div function.
- One natural sub-module: f_div_core, containing the counter, clk_out and tick flops, with inputs N, run, and restart, and a boundary output.
- f_div_ctrl holds the FSM and the handshake.

Test Plan:
- Reset then en=1 with DEFAULT_DIV=2 -> clk_out toggles every cycle, tick every 2nd cycle, cur_div=2.
- In RUN at N=2, request div_val=5 mid-period -> busy=1 until the boundary; at the boundary cur_div=5 and div_ack pulses once. clk_out then shows 2 high / 3 low and tick has a period of 5, with no runt pulse.
- Request div_val=1, then div_val=0 -> each gives div_ack=div_err=1 for one cycle, while cur_div and clk_out continue unchanged.
- N=4 running, en dropped at cnt=1 -> counting continues through cnt=3 (STOP), then OFF with clk_out=0. en=1 later restarts at cnt=0 with clk_out=1.
- Running N=3, rst pulled low at cnt=1 -> all outputs clear immediately, cur_div=2. After release, nothing runs until en=1.
- In OFF, request div_val=15 -> div_ack next cycle, cur_div=15. Then en=1 -> 7 high / 8 low, tick every 15 cycles.
